rtc_bus_scheduler: RTL and testbench

- Owns the multiplexed RTC bus (CS/AD/RD/WR plus the 8-bit AD lines) and decides which engine drives it, by issuing the 3-bit mode code (trol) to the read, write and init engines.
- Runs one init sequence after reset, then periodic read sweeps, and on-demand write sweeps from the user edit path.
- Inserts an idle gap with trol=0 between transactions, so each engine's address counter rewinds before its next sweep.

---
 rtl/rtc_pkg.sv | 35 +++
 rtl/rtc_period_timer.sv | 30 +++
 rtl/rtc_bus_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus scheduler and the engines it drives:
// trol mode codes, scheduler state encoding and small helpers.
package rtc_pkg;

    // Mode codes on trol; the read, write and init engines decode these
    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_INIT  = 3'd1;
    localparam logic [2:0] MODE_READ  = 3'd2;
    localparam logic [2:0] MODE_WRITE = 3'd4;

    // Scheduler states
    typedef enum logic [2:0] {
        S_PWAIT = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Bus mode driven while sitting in a given state
    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            S_INIT:  return MODE_INIT;
            S_READ:  return MODE_READ;
            S_WRITE: return MODE_WRITE;
            default: return MODE_IDLE;
        endcase
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rtc_period_timer.sv
// Free-running wrap counter that raises tick_c for one cycle every PERIOD
// enabled cycles; the count holds while en is low.
module rtc_period_timer #(
    parameter int unsigned PERIOD = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Tick on the last count of each period
    always_comb begin
        tick_c = en && (cnt_q == CNT_W'(PERIOD - 1));
    end

    // Count while enabled, wrapping to zero on the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: owns the multiplexed RTC bus and hands it to the init,
// read or write engine through the trol mode code. One init after reset,
// periodic read sweeps, on-demand write sweeps, with an idle gap (trol=0)
// between transactions so the engines rewind their address counters.
// Optional build macro RTC_SCHED_STATS_EN adds completion/timeout counters.
module rtc_bus_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned READ_PERIOD = 1000000,
    parameter int unsigned INIT_WAIT   = 1000,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic        init_done,
    input  logic        rd_done,
    input  logic        wr_done,
    output logic [2:0]  trol,
    output logic        busy,
    output logic        wr_ack,
    output logic        err
`ifdef RTC_SCHED_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [7:0]  to_count
`endif
);

    // One shared counter serves the power-up wait, transaction timeout and gap
    localparam int unsigned CNT_MAX = max_u(max_u(INIT_WAIT, TIMEOUT), GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_pend_q, wr_pend_d;
    logic             rd_due_q, rd_due_d;
    logic             last_was_wr_q, last_was_wr_d;
    logic             timer_en_q, timer_en_d;
    logic [2:0]       trol_d;
    logic             busy_d;
    logic             wr_ack_d;
    logic             err_d;
    logic             timeout_c;
    logic             tick_c;

    rtc_period_timer #(
        .PERIOD (READ_PERIOD)
    ) u_period_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (timer_en_q),
        .tick_c (tick_c)
    );

    // Next state, flag updates and registered output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        timeout_c     = 1'b0;
        wr_pend_d     = wr_pend_q;
        rd_due_d      = rd_due_q;
        last_was_wr_d = last_was_wr_q;
        timer_en_d    = timer_en_q;

        case (state_q)
            S_PWAIT: begin
                if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (init_done) begin
                    state_d = S_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_GAP;
                    timeout_c = 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                // Write wins unless a read is also due and the last job was a write
                if (wr_pend_q && (!rd_due_q || !last_was_wr_q)) begin
                    state_d = S_WRITE;
                end else if (rd_due_q) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rd_done) begin
                    state_d  = S_GAP;
                    rd_due_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_GAP;
                    timeout_c = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_done) begin
                    state_d = S_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_GAP;
                    timeout_c = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_PWAIT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Write request is consumed when the write starts; a same-cycle request re-arms it
        if ((state_q == S_IDLE) && (state_d == S_WRITE)) begin
            wr_pend_d = 1'b0;
        end
        if (wr_req && (state_q != S_PWAIT)) begin
            wr_pend_d = 1'b1;
        end

        // A new period overrides a same-cycle read completion
        if (tick_c) begin
            rd_due_d = 1'b1;
        end

        if ((state_q == S_WRITE) && (state_d != S_WRITE)) begin
            last_was_wr_d = 1'b1;
        end else if ((state_q == S_READ) && (state_d != S_READ)) begin
            last_was_wr_d = 1'b0;
        end

        // The period timer starts on the first idle entry after init and then free-runs
        if ((state_q == S_GAP) && (state_d == S_IDLE)) begin
            timer_en_d = 1'b1;
        end

        trol_d   = mode_of(state_d);
        busy_d   = (mode_of(state_d) != MODE_IDLE);
        wr_ack_d = (state_q == S_IDLE) && (state_d == S_WRITE);
        err_d    = err_q_or_timeout(err, timeout_c);
    end

    function automatic logic err_q_or_timeout(input logic e, input logic t);
        return e | t;
    endfunction

    // State, flags and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_PWAIT;
            cnt_q         <= '0;
            wr_pend_q     <= 1'b0;
            rd_due_q      <= 1'b0;
            last_was_wr_q <= 1'b0;
            timer_en_q    <= 1'b0;
            trol          <= MODE_IDLE;
            busy          <= 1'b0;
            wr_ack        <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_pend_q     <= wr_pend_d;
            rd_due_q      <= rd_due_d;
            last_was_wr_q <= last_was_wr_d;
            timer_en_q    <= timer_en_d;
            trol          <= trol_d;
            busy          <= busy_d;
            wr_ack        <= wr_ack_d;
            err           <= err_d;
        end
    end

`ifdef RTC_SCHED_STATS_EN
    logic rd_ok_c;
    logic wr_ok_c;

    assign rd_ok_c = (state_q == S_READ) && rd_done;
    assign wr_ok_c = (state_q == S_WRITE) && wr_done;

    // Completion counters wrap; timeout counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
            to_count <= '0;
        end else begin
            if (rd_ok_c) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_ok_c) begin
                wr_count <= wr_count + 16'd1;
            end
            if (timeout_c && (to_count != 8'hFF)) begin
                to_count <= to_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: a transaction-level model
// checked every cycle, plus hand-computed timing pins on directed scenarios.
module tb_rtc_bus_scheduler;

    localparam int P_INIT_WAIT = 10;
    localparam int P_GAP       = 4;
    localparam int P_TIMEOUT   = 50;
    localparam int P_PERIOD    = 100;

    logic       clk;
    logic       reset;
    logic       wr_req;
    logic       init_done;
    logic       rd_done;
    logic       wr_done;
    logic [2:0] trol;
    logic       busy;
    logic       wr_ack;
    logic       err;
`ifdef RTC_SCHED_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [7:0]  to_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    rtc_bus_scheduler #(
        .READ_PERIOD (P_PERIOD),
        .INIT_WAIT   (P_INIT_WAIT),
        .GAP_CYCLES  (P_GAP),
        .TIMEOUT     (P_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .init_done (init_done),
        .rd_done   (rd_done),
        .wr_done   (wr_done),
        .trol      (trol),
        .busy      (busy),
        .wr_ack    (wr_ack),
        .err       (err)
`ifdef RTC_SCHED_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .to_count  (to_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase is tracked as: power-up countdown, active job (trol!=0),
    // gap countdown, or idle (all of those zero).
    int m_trol, m_pwait, m_gap, m_age, m_tcyc;
    bit m_err, m_ack, m_pend, m_due, m_lastwr, m_ton;
    bit s_in_pwait, s_tick, s_done, s_ton_old;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_trol = 0; m_pwait = P_INIT_WAIT; m_gap = 0; m_age = 0; m_tcyc = 0;
            m_err = 0; m_ack = 0; m_pend = 0; m_due = 0; m_lastwr = 0; m_ton = 0;
        end else begin
            s_in_pwait = (m_pwait > 0);
            s_ton_old  = m_ton;
            s_tick     = m_ton && ((m_tcyc % P_PERIOD) == P_PERIOD - 1);
            m_ack = 0;
            if (m_pwait > 0) begin
                m_pwait = m_pwait - 1;
                if (m_pwait == 0) begin
                    m_trol = 1;
                    m_age  = 0;
                end
            end else if (m_trol != 0) begin
                s_done = (m_trol == 1 && init_done) || (m_trol == 2 && rd_done) ||
                         (m_trol == 4 && wr_done);
                if (s_done || m_age == P_TIMEOUT - 1) begin
                    if (!s_done) m_err = 1;
                    if (m_trol == 4) m_lastwr = 1;
                    if (m_trol == 2) begin
                        m_lastwr = 0;
                        if (s_done) m_due = 0;
                    end
                    m_trol = 0;
                    m_gap  = P_GAP;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_ton = 1;
            end else begin
                if (m_pend && !(m_due && m_lastwr)) begin
                    m_trol = 4; m_ack = 1; m_pend = 0; m_age = 0;
                end else if (m_due) begin
                    m_trol = 2; m_age = 0;
                end
            end
            if (wr_req && !s_in_pwait) m_pend = 1;
            if (s_tick) m_due = 1;
            if (s_ton_old) m_tcyc = m_tcyc + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("trol",   int'(trol),   m_trol);
            check("busy",   int'(busy),   int'(m_trol != 0));
            check("wr_ack", int'(wr_ack), int'(m_ack));
            check("err",    int'(err),    int'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_wr(input int n);
        to_cyc(n); wr_req = 1'b1; to_cyc(n + 1); wr_req = 1'b0;
    endtask

    task automatic pulse_init(input int n);
        to_cyc(n); init_done = 1'b1; to_cyc(n + 1); init_done = 1'b0;
    endtask

    task automatic pulse_rd(input int n);
        to_cyc(n); rd_done = 1'b1; to_cyc(n + 1); rd_done = 1'b0;
    endtask

    task automatic pulse_wd(input int n);
        to_cyc(n); wr_done = 1'b1; to_cyc(n + 1); wr_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_req = 1'b0; init_done = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_trol",   int'(trol),   0);
        check("reset_busy",   int'(busy),   0);
        check("reset_wr_ack", int'(wr_ack), 0);
        check("reset_err",    int'(err),    0);
        reset = 1'b0;

        // Power-up wait then init; wr_req during the wait is dropped
        pulse_wr(3);
        to_cyc(9);   check("pwait_trol", int'(trol), 0);
        to_cyc(10);  check("init_start", int'(trol), 1);
        pulse_init(15);
        check("init_busy_end", int'(busy), 0);
        to_cyc(19);  check("gap_trol", int'(trol), 0);
        to_cyc(20);  check("idle_err", int'(err), 0);

        // First period: timer starts at edge 20, read at edge 121
        to_cyc(120); check("pre_read", int'(trol), 0);
        to_cyc(121); check("read_start", int'(trol), 2);
        pulse_wr(125); pulse_wr(130); pulse_wr(135);
        pulse_rd(141);
        to_cyc(146); check("post_read_gap", int'(trol), 0);
        to_cyc(147); check("coalesced_write", int'(trol), 4);
        check("coalesced_ack", int'(wr_ack), 1);
        to_cyc(148); check("ack_one_cycle", int'(wr_ack), 0);
        pulse_wd(155);
        to_cyc(200); check("no_second_write", int'(trol), 0);

        // Write outlasts next period and gets a follow-up request: read goes first
        pulse_wr(210);
        to_cyc(212); check("write2_start", int'(trol), 4);
        pulse_wr(215);
        pulse_wd(225);
        to_cyc(231); check("anti_starve_read", int'(trol), 2);
        pulse_rd(240);
        to_cyc(246); check("followup_write", int'(trol), 4);

        // No wr_done: times out after 50 cycles
        to_cyc(295); check("timeout_last", int'(trol), 4);
        to_cyc(296); check("timeout_trol", int'(trol), 0);
        check("timeout_err", int'(err), 1);
        to_cyc(321); check("read_after_to", int'(trol), 2);
        pulse_rd(330);
        to_cyc(340); check("err_sticky", int'(err), 1);

        // Asynchronous reset in the middle of a write
        pulse_wr(345);
        to_cyc(350); check("pre_reset_write", int'(trol), 4);
        #2 reset = 1'b1;
        #1 check("async_reset_trol", int'(trol), 0);
        check("async_reset_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        to_cyc(9);   check("reinit_pwait", int'(trol), 0);
        to_cyc(10);  check("reinit_start", int'(trol), 1);
        pulse_init(12);

        // Stray rd_done ignored; wr_done on the final timeout cycle counts as done
        pulse_wr(20);
        to_cyc(22);  check("write3_start", int'(trol), 4);
        pulse_rd(30);
        to_cyc(71);  check("write3_last", int'(trol), 4);
        pulse_wd(71);
        check("done_wins_trol", int'(trol), 0);
        to_cyc(75);  check("done_wins_err", int'(err), 0);
        to_cyc(125);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
